// File: rtl/mrd_mem_pkt.sv
// mrd_mem_pkt: shared widths, bank/lane counts and write-back FSM states
// for the mixed-radix DFT memory.
package mrd_mem_pkt;
    localparam int         wADDR       = 9;
    localparam int         wDATA       = 30;
    localparam int         NBANK       = 7;
    localparam int         NLANE       = 5;
    localparam logic [2:0] INVALID_IDX = 3'd7;
    typedef enum logic [1:0] {IDLE, WR, END} wrback_state_e;
endpackage

// File: rtl/mrd_lane2bank_mux.sv
// mrd_lane2bank_mux: picks the lowest live lane aimed at bank BANK.
// Multi-hit detection exists only when MRD_WRBACK_CONFLICT_CHK_EN is defined.
module mrd_lane2bank_mux import mrd_mem_pkt::*; #(
    parameter int         AW   = wADDR,
    parameter int         DW   = wDATA,
    parameter int         NL   = NLANE,
    parameter logic [2:0] BANK = 3'd0
) (
    input  logic [NL-1:0]         live,
    input  logic [NL-1:0][2:0]    idx,
    input  logic [NL-1:0][AW-1:0] addr,
    input  logic [NL-1:0][DW-1:0] d_real,
    input  logic [NL-1:0][DW-1:0] d_imag,
    output logic                  hit,
    output logic [AW-1:0]         sel_addr,
    output logic [DW-1:0]         sel_real,
    output logic [DW-1:0]         sel_imag,
    output logic                  multi
);
    logic [NL-1:0] match;

    // Scan from the top lane down so the lowest matching lane is written last and wins.
    always_comb begin
        match    = '0;
        sel_addr = '0;
        sel_real = '0;
        sel_imag = '0;
        for (int k = NL - 1; k >= 0; k--) begin
            match[k] = live[k] && (idx[k] == BANK);
            if (match[k]) begin
                sel_addr = addr[k];
                sel_real = d_real[k];
                sel_imag = d_imag[k];
            end
        end
    end

    assign hit = |match;

`ifdef MRD_WRBACK_CONFLICT_CHK_EN
    assign multi = $countones(match) > 1;
`else
    assign multi = 1'b0;
`endif

endmodule

// File: rtl/mrd_bfly_wrback.sv
// mrd_bfly_wrback: scatters butterfly lanes into the memory banks and tracks stage completion.
// Define MRD_WRBACK_CONFLICT_CHK_EN to enable lane-bank conflict reporting on err_flags[0].
module mrd_bfly_wrback #(
    parameter int wADDR = mrd_mem_pkt::wADDR,
    parameter int wDATA = mrd_mem_pkt::wDATA,
    parameter int NBANK = mrd_mem_pkt::NBANK,
    parameter int NLANE = mrd_mem_pkt::NLANE
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          stage_start,
    input  logic                          stage_clr,
    input  logic [11:0]                   cnt_wr_stop,
    input  logic                          in_valid,
    input  logic [2:0]                    in_factor,
    input  logic [NLANE-1:0][2:0]         in_bank_index,
    input  logic [NLANE-1:0][wADDR-1:0]   in_bank_addr,
    input  logic [NLANE-1:0][wDATA-1:0]   in_d_real,
    input  logic [NLANE-1:0][wDATA-1:0]   in_d_imag,
    output logic [NBANK-1:0]              wren,
    output logic [NBANK-1:0][wADDR-1:0]   wraddr,
    output logic [NBANK-1:0][wDATA-1:0]   wrdata_real,
    output logic [NBANK-1:0][wDATA-1:0]   wrdata_imag,
    output logic                          wr_end,
    output logic [2:0]                    cnt_stage_wr,
    output logic                          busy,
    output logic [2:0]                    err_flags
);
    import mrd_mem_pkt::*;

    wrback_state_e               state_q, state_d;
    logic [11:0]                 stop_q, stop_d, cnt_bfly_q, cnt_bfly_d;
    logic [2:0]                  cnt_stage_q, cnt_stage_d, err_q, err_d, err_base;
    logic [NBANK-1:0]            wren_q, wren_d, multi;
    logic [NBANK-1:0][wADDR-1:0] wraddr_q, wraddr_d;
    logic [NBANK-1:0][wDATA-1:0] wrdata_real_q, wrdata_real_d, wrdata_imag_q, wrdata_imag_d;
    logic [2:0]                  factor;
    logic [NLANE-1:0]            live;
    logic                        last;

    assign factor = (in_factor == 3'd0 || in_factor > 3'd5) ? 3'd5 : in_factor;

    always_comb begin
        live = '0;
        for (int k = 0; k < NLANE; k++)
            live[k] = in_valid && (int'(factor) > k) && (in_bank_index[k] != INVALID_IDX);
    end

    for (genvar b = 0; b < NBANK; b++) begin : g_bank
        mrd_lane2bank_mux #(.AW(wADDR), .DW(wDATA), .NL(NLANE), .BANK(3'(b))) u_mux (
            .live     (live),
            .idx      (in_bank_index),
            .addr     (in_bank_addr),
            .d_real   (in_d_real),
            .d_imag   (in_d_imag),
            .hit      (wren_d[b]),
            .sel_addr (wraddr_d[b]),
            .sel_real (wrdata_real_d[b]),
            .sel_imag (wrdata_imag_d[b]),
            .multi    (multi[b])
        );
    end

    // A restart inside WR takes precedence over completing the stage.
    assign last = !stage_start && in_valid && (cnt_bfly_q + 12'd1 == stop_q);

    always_comb begin
        state_d = (state_q != WR) ? (stage_start ? WR : IDLE) : (last ? END : WR);
    end

    always_comb begin
        stop_d      = stage_start ? cnt_wr_stop : stop_q;
        cnt_bfly_d  = stage_start ? 12'd0 : (state_q == WR && in_valid) ? cnt_bfly_q + 12'd1 : cnt_bfly_q;
        cnt_stage_d = stage_clr ? 3'd0 : (state_q == END) ? cnt_stage_q + 3'd1 : cnt_stage_q;
        err_base    = (stage_start && state_q != WR) ? 3'd0 : err_q;
        err_d       = err_base | {stage_start && state_q == WR, in_valid && state_q != WR, |multi};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stop_q        <= '0;
            cnt_bfly_q    <= '0;
            cnt_stage_q   <= '0;
            err_q         <= '0;
            wren_q        <= '0;
            wraddr_q      <= '0;
            wrdata_real_q <= '0;
            wrdata_imag_q <= '0;
        end else begin
            stop_q        <= stop_d;
            cnt_bfly_q    <= cnt_bfly_d;
            cnt_stage_q   <= cnt_stage_d;
            err_q         <= err_d;
            wren_q        <= wren_d;
            wraddr_q      <= wraddr_d;
            wrdata_real_q <= wrdata_real_d;
            wrdata_imag_q <= wrdata_imag_d;
        end
    end

    always_comb begin
        wr_end       = state_q == END;
        busy         = state_q != IDLE;
        cnt_stage_wr = cnt_stage_q;
        err_flags    = err_q;
        wren         = wren_q;
        wraddr       = wraddr_q;
        wrdata_real  = wrdata_real_q;
        wrdata_imag  = wrdata_imag_q;
    end

endmodule

// File: tb/tb_mrd_bfly_wrback.sv
// tb_mrd_bfly_wrback: directed vectors for the write-back scatter, stage FSM and error flags.
module tb_mrd_bfly_wrback;
    localparam int AW = 9;
    localparam int DW = 30;
`ifdef MRD_WRBACK_CONFLICT_CHK_EN
    localparam logic CONF = 1'b1;
`else
    localparam logic CONF = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  stage_start = 1'b0;
    logic                  stage_clr = 1'b0;
    logic [11:0]           cnt_wr_stop = '0;
    logic                  in_valid = 1'b0;
    logic [2:0]            in_factor = 3'd5;
    logic [4:0][2:0]       in_bank_index = '1;
    logic [4:0][AW-1:0]    in_bank_addr;
    logic [4:0][DW-1:0]    in_d_real;
    logic [4:0][DW-1:0]    in_d_imag;
    logic [6:0]            wren;
    logic [6:0][AW-1:0]    wraddr;
    logic [6:0][DW-1:0]    wrdata_real;
    logic [6:0][DW-1:0]    wrdata_imag;
    logic                  wr_end;
    logic [2:0]            cnt_stage_wr;
    logic                  busy;
    logic [2:0]            err_flags;
    int                    n_chk = 0;
    int                    n_bad = 0;

    always #5 clk = ~clk;

    mrd_bfly_wrback dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stage_start   (stage_start),
        .stage_clr     (stage_clr),
        .cnt_wr_stop   (cnt_wr_stop),
        .in_valid      (in_valid),
        .in_factor     (in_factor),
        .in_bank_index (in_bank_index),
        .in_bank_addr  (in_bank_addr),
        .in_d_real     (in_d_real),
        .in_d_imag     (in_d_imag),
        .wren          (wren),
        .wraddr        (wraddr),
        .wrdata_real   (wrdata_real),
        .wrdata_imag   (wrdata_imag),
        .wr_end        (wr_end),
        .cnt_stage_wr  (cnt_stage_wr),
        .busy          (busy),
        .err_flags     (err_flags)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic init_lanes();
        for (int k = 0; k < 5; k++) begin
            in_bank_addr[k] = AW'(9'h100 + k);
            in_d_real[k]    = DW'(30'h1000 + k);
            in_d_imag[k]    = DW'(30'h2000 + k);
        end
    endtask

    initial begin
        init_lanes();
        #12;
        chk("rst_wren", 32'(wren), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_cnt", 32'(cnt_stage_wr), 32'h0);
        chk("rst_err", 32'(err_flags), 32'h0);
        chk("rst_wr_end", 32'(wr_end), 32'h0);
        rst_n = 1'b1;
        step();

        // radix-5 stage, three butterflies
        stage_start = 1'b1; cnt_wr_stop = 12'd3; in_factor = 3'd5;
        step();
        stage_start = 1'b0;
        chk("r5_busy", 32'(busy), 32'h1);
        in_valid = 1'b1; in_bank_index = {3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
        step();
        chk("r5_wren1", 32'(wren), 32'h1F);
        chk("r5_addr3", 32'(wraddr[3]), 32'h103);
        chk("r5_end1", 32'(wr_end), 32'h0);
        in_bank_index = {3'd2, 3'd1, 3'd0, 3'd6, 3'd5};
        step();
        chk("r5_wren2", 32'(wren), 32'h67);
        chk("r5_imag6", 32'(wrdata_imag[6]), 32'h2001);
        chk("r5_end2", 32'(wr_end), 32'h0);
        in_bank_index = {3'd0, 3'd6, 3'd5, 3'd4, 3'd3};
        step();
        chk("r5_wren3", 32'(wren), 32'h79);
        chk("r5_end3", 32'(wr_end), 32'h1);
        chk("r5_cnt_in_end", 32'(cnt_stage_wr), 32'h0);
        in_valid = 1'b0;
        step();
        chk("r5_cnt", 32'(cnt_stage_wr), 32'h1);
        chk("r5_idle", 32'(busy), 32'h0);
        chk("r5_wren_off", 32'(wren), 32'h0);
        chk("r5_err", 32'(err_flags), 32'h0);

        // radix-3 masking then lane conflict
        stage_start = 1'b1; cnt_wr_stop = 12'd2;
        step();
        stage_start = 1'b0;
        in_valid = 1'b1; in_factor = 3'd3; in_bank_index = {3'd5, 3'd2, 3'd6, 3'd1, 3'd0};
        step();
        chk("r3_wren", 32'(wren), 32'h43);
        chk("r3_addr6", 32'(wraddr[6]), 32'h102);
        chk("r3_addr2_clear", 32'(wraddr[2]), 32'h0);
        chk("r3_err", 32'(err_flags), 32'h0);
        in_factor = 3'd5; in_bank_index = {3'd7, 3'd7, 3'd4, 3'd7, 3'd4};
        in_bank_addr[0] = 9'h010; in_bank_addr[2] = 9'h020;
        step();
        chk("cf_wren", 32'(wren), 32'h10);
        chk("cf_addr4", 32'(wraddr[4]), 32'h010);
        chk("cf_real4", 32'(wrdata_real[4]), 32'h1000);
        chk("cf_end", 32'(wr_end), 32'h1);
        chk("cf_err0", 32'(err_flags[0]), 32'(CONF));
        in_valid = 1'b0;
        init_lanes();
        step();
        chk("cf_cnt", 32'(cnt_stage_wr), 32'h2);

        // stray valid in IDLE; factor 0 behaves as radix-5
        in_valid = 1'b1; in_factor = 3'd0; in_bank_index = {3'd3, 3'd7, 3'd7, 3'd7, 3'd1};
        step();
        chk("st_wren", 32'(wren), 32'h0A);
        chk("st_err", 32'(err_flags), 32'({1'b0, 1'b1, CONF}));
        chk("st_cnt", 32'(cnt_stage_wr), 32'h2);
        chk("st_busy", 32'(busy), 32'h0);
        in_valid = 1'b0; in_factor = 3'd5;
        step();

        // back-to-back stages: restart in the END cycle
        stage_start = 1'b1; cnt_wr_stop = 12'd1;
        step();
        stage_start = 1'b0;
        chk("bb_err_clr", 32'(err_flags), 32'h0);
        in_valid = 1'b1; in_bank_index = {3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
        step();
        chk("bb_end1", 32'(wr_end), 32'h1);
        in_valid = 1'b0; stage_start = 1'b1; cnt_wr_stop = 12'd2;
        step();
        stage_start = 1'b0;
        chk("bb_busy", 32'(busy), 32'h1);
        chk("bb_end_once", 32'(wr_end), 32'h0);
        chk("bb_cnt3", 32'(cnt_stage_wr), 32'h3);
        in_valid = 1'b1;
        step();
        chk("bb_mid", 32'(wr_end), 32'h0);
        step();
        chk("bb_end2", 32'(wr_end), 32'h1);
        in_valid = 1'b0;
        step();
        chk("bb_cnt4", 32'(cnt_stage_wr), 32'h4);
        chk("bb_err", 32'(err_flags), 32'h0);

        // stage_start inside WR restarts the count and flags err[2]
        stage_start = 1'b1; cnt_wr_stop = 12'd2;
        step();
        in_valid = 1'b1;
        step();
        stage_start = 1'b0;
        chk("rs_err2", 32'(err_flags), 32'h4);
        step();
        chk("rs_no_end", 32'(wr_end), 32'h0);
        in_valid = 1'b0;
        step();

        // async reset mid-stage
        rst_n = 1'b0;
        #1;
        chk("ar_wren", 32'(wren), 32'h0);
        chk("ar_busy", 32'(busy), 32'h0);
        chk("ar_cnt", 32'(cnt_stage_wr), 32'h0);
        chk("ar_err", 32'(err_flags), 32'h0);
        rst_n = 1'b1;
        step();

        // three stages, then stage_clr on the fourth END
        for (int s = 0; s < 4; s++) begin
            stage_start = 1'b1; cnt_wr_stop = 12'd1;
            step();
            stage_start = 1'b0; in_valid = 1'b1;
            step();
            in_valid = 1'b0;
            stage_clr = (s == 3);
            step();
            stage_clr = 1'b0;
            if (s == 2) chk("cl_cnt3", 32'(cnt_stage_wr), 32'h3);
        end
        chk("cl_cnt0", 32'(cnt_stage_wr), 32'h0);
        chk("cl_idle", 32'(busy), 32'h0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
